rf: RTL
=======

# rf

Register-read stage between the issue stage and the execution units. Each cycle it accepts up to four issued instructions (mult, alu1, alu2, address ports), reads their physical source operands from a 64-entry physical register file, and delivers instruction plus operand data to execution. The four-port writeback from execution is bypassed into same-cycle reads. A ROB flush kills in-flight instructions.

## Interface
Parameters:
- INST_WIDTH, 56, issued instruction width.
- PRG_NUM, 64, physical registers.
- PRG_IDX_BITS, 6, physical register index width.
- DATA_WIDTH, 16, register data width.
- WB_WIDTH, 1+PRG_IDX_BITS+DATA_WIDTH (23), one writeback port: {vld, idx, data}.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- mul_ins_frm_is, alu1_ins_frm_is, alu2_ins_frm_is, adr_ins_frm_is  in  INST_WIDTH each  issued instructions.
- wb_frm_exe  in  4*WB_WIDTH  writeback ports 0..3, port k at [k*WB_WIDTH +: WB_WIDTH].
- fls_frm_rob  in  7  {vld, 6-bit branch idx}; only bit 6 is used (full flush).
- mul_ins_to_exe, alu1_ins_to_exe, alu2_ins_to_exe, adr_ins_to_exe  out  INST_WIDTH each  registered instruction.
- mul_src_to_exe, alu1_src_to_exe, alu2_src_to_exe, adr_src_to_exe  out  2*DATA_WIDTH each  {src1 data, src2 data}.

## Operation
- Instruction fields: [55] inst vld; [54:48] psrc1 {vld, idx}; [47:41] psrc2 {vld, idx}; [40:34] pdest {vld, idx}; [33:0] control/immediate, passed through untouched.
- Register file: PRG_NUM x DATA_WIDTH flops. Write port k writes data to idx when its vld=1.
- Same-cycle write collision on one idx: highest port number wins, for both storage and bypass.
- Read per source: if the source vld=0, the data is 0. Otherwise, if any writeback this cycle targets idx, use the bypassed data with the same priority. Otherwise use the stored value.
- Pipeline register per issue port: captures the instruction and both source data every cycle.
- Input with inst vld=0: captured as all-zero, so the output vld stays 0 and data is 0.
- Flush (fls_frm_rob[6]=1): all four output stages load zero on the next edge, discarding that cycle's inputs.
  - Writebacks in the flush cycle still update the register file.
- No stall: the issue stage only issues to ready units, so the block accepts every cycle.

## Timing
- Latency is 1 cycle. An instruction presented in cycle N appears at the outputs after edge N+1, with data reflecting all writebacks up to and including cycle N.
- A writeback in cycle N is stored at edge N+1 and is visible to reads in cycle N via bypass.
- Reset (rst_n=0 at an edge): all register file entries and all outputs go to 0.
  - Reset overrides flush and writeback.
  - Reset mid-stream discards in-flight instructions; the first input after release appears one cycle later.
- Flush together with an input: the input is dropped and the outputs are 0 after the edge.
- All outputs are driven directly from flops; there is no combinational input-to-output path.

## Structure
- Shared package rf_pkg holds:
  - field bit positions (BIT_INST_VLD=55, BIT_PSRC1 range, BIT_PSRC2 range, BIT_PDEST range);
  - WB_WIDTH;
  - port indices (MULT=0, ADD1=1, ADD2=2, ADDR=3), matching the issue stage's function-unit bit order.
- One sub-module, rf_rd_byp: a combinational read mux for one source operand, covering the stored read, the 4-port priority bypass and the source-valid gating. It is instantiated 8 times.
- The top level holds the register array, write logic and the four output pipeline registers.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with random inputs, then read p0..p63 via alu1 instructions. Required: all outputs 0 during reset and all reads return 0x0000.
- **Write then read:** cycle 0, wb port 0 writes p5=0x1234. Cycle 1, alu1 issues psrc1=p5, psrc2 invalid. Required after edge 2: alu1_src_to_exe={0x1234, 0x0000} and alu1_ins_to_exe equal to the input.
- **Bypass:** in the same cycle, wb port 2 writes p9=0xBEEF and the mult port reads psrc1=p9, psrc2=p9. Required next cycle: mul_src_to_exe={0xBEEF, 0xBEEF}.
- **Collision priority:** ports 1 and 3 both write p7 in one cycle (0x1111, 0x3333) while adr reads p7. Required: bypass data 0x3333, and a later read of p7 returns 0x3333.
- **Flush:** all four ports are valid and fls_frm_rob=7'b1_000011, with wb port 0 writing p2=0x00AA. Required: all outputs 0 next cycle and a later read of p2 returns 0x00AA.
- **Full throughput:** 100 cycles of random 4-wide issue plus random writebacks, checked against a reference model. Required: outputs match exactly each cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg : shared definitions for the register-read stage.
//   - instruction field bit positions (valid, psrc1, psrc2, pdest)
//   - writeback port layout {vld, idx, data}
//   - issue port indices, in the issue stage's function-unit bit order
// ---------------------------------------------------------------------------
package rf_pkg;

  localparam int INST_WIDTH   = 56;
  localparam int PRG_NUM      = 64;
  localparam int PRG_IDX_BITS = 6;
  localparam int DATA_WIDTH   = 16;
  localparam int WB_WIDTH     = 1 + PRG_IDX_BITS + DATA_WIDTH;
  localparam int NUM_PORTS    = 4;

  // Instruction fields
  localparam int BIT_INST_VLD = 55;
  localparam int BIT_PSRC1_HI = 54;
  localparam int BIT_PSRC1_LO = 48;
  localparam int BIT_PSRC2_HI = 47;
  localparam int BIT_PSRC2_LO = 41;
  localparam int BIT_PDEST_HI = 40;
  localparam int BIT_PDEST_LO = 34;

  // Issue / execution port indices
  localparam int MULT = 0;
  localparam int ADD1 = 1;
  localparam int ADD2 = 2;
  localparam int ADDR = 3;

  // Bit 6 of the ROB flush bundle requests a full flush
  localparam int BIT_FLS_VLD = 6;

endpackage

// File: rtl/rf_rd_byp.sv
// ---------------------------------------------------------------------------
// rf_rd_byp : combinational read of one source operand.
//   Selects the stored register value, overrides it with a same-cycle
//   writeback to the same index (higher port number wins), and forces zero
//   when the source is not valid.
// Ports:
//   i_src   [PRG_IDX_BITS:0]         {vld, idx} of the source operand
//   i_prf   [PRG_NUM*DATA_WIDTH-1:0] flattened register file contents
//   i_wb    [4*WB_WIDTH-1:0]         writeback ports, port k at k*WB_WIDTH
//   o_data  [DATA_WIDTH-1:0]         operand value
// ---------------------------------------------------------------------------
module rf_rd_byp
  import rf_pkg::*;
#(
  parameter int PRG_NUM_P      = PRG_NUM,
  parameter int PRG_IDX_BITS_P = PRG_IDX_BITS,
  parameter int DATA_WIDTH_P   = DATA_WIDTH,
  parameter int WB_WIDTH_P     = WB_WIDTH
) (
  input  logic [PRG_IDX_BITS_P:0]           i_src,
  input  logic [PRG_NUM_P*DATA_WIDTH_P-1:0] i_prf,
  input  logic [NUM_PORTS*WB_WIDTH_P-1:0]   i_wb,
  output logic [DATA_WIDTH_P-1:0]           o_data
);

  logic                      w_src_vld;
  logic [PRG_IDX_BITS_P-1:0] w_src_idx;
  logic [DATA_WIDTH_P-1:0]   w_data;

  assign w_src_vld = i_src[PRG_IDX_BITS_P];
  assign w_src_idx = i_src[PRG_IDX_BITS_P-1:0];

  always_comb begin
    w_data = i_prf[int'(w_src_idx)*DATA_WIDTH_P +: DATA_WIDTH_P];
    // Ascending scan: a later (higher-numbered) matching port overrides.
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (i_wb[k*WB_WIDTH_P + WB_WIDTH_P - 1] &&
          (i_wb[k*WB_WIDTH_P + DATA_WIDTH_P +: PRG_IDX_BITS_P] == w_src_idx)) begin
        w_data = i_wb[k*WB_WIDTH_P +: DATA_WIDTH_P];
      end
    end
  end

  assign o_data = w_src_vld ? w_data : '0;

endmodule

// File: rtl/rf.sv
// ---------------------------------------------------------------------------
// rf : register-read stage between issue and execution.
//   Holds a 64 x 16 physical register file written by four writeback ports,
//   reads two source operands per issued instruction (with same-cycle
//   writeback bypass) and registers instruction + operands for execution.
//   A ROB flush zeroes all four output stages on the next edge.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   {mul,alu1,alu2,adr}_ins_frm_is issued instructions  [INST_WIDTH]
//   wb_frm_exe                     4 writeback ports    [4*WB_WIDTH]
//   fls_frm_rob                    {vld, branch idx}; only vld is used
//   {mul,alu1,alu2,adr}_ins_to_exe registered instructions
//   {mul,alu1,alu2,adr}_src_to_exe registered {src1, src2} data
// ---------------------------------------------------------------------------
module rf
  import rf_pkg::*;
#(
  parameter int INST_WIDTH_P   = INST_WIDTH,
  parameter int PRG_NUM_P      = PRG_NUM,
  parameter int PRG_IDX_BITS_P = PRG_IDX_BITS,
  parameter int DATA_WIDTH_P   = DATA_WIDTH,
  parameter int WB_WIDTH_P     = 1 + PRG_IDX_BITS_P + DATA_WIDTH_P
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [INST_WIDTH_P-1:0]             mul_ins_frm_is,
  input  logic [INST_WIDTH_P-1:0]             alu1_ins_frm_is,
  input  logic [INST_WIDTH_P-1:0]             alu2_ins_frm_is,
  input  logic [INST_WIDTH_P-1:0]             adr_ins_frm_is,
  input  logic [NUM_PORTS*WB_WIDTH_P-1:0]     wb_frm_exe,
  input  logic [6:0]                          fls_frm_rob,
  output logic [INST_WIDTH_P-1:0]             mul_ins_to_exe,
  output logic [INST_WIDTH_P-1:0]             alu1_ins_to_exe,
  output logic [INST_WIDTH_P-1:0]             alu2_ins_to_exe,
  output logic [INST_WIDTH_P-1:0]             adr_ins_to_exe,
  output logic [2*DATA_WIDTH_P-1:0]           mul_src_to_exe,
  output logic [2*DATA_WIDTH_P-1:0]           alu1_src_to_exe,
  output logic [2*DATA_WIDTH_P-1:0]           alu2_src_to_exe,
  output logic [2*DATA_WIDTH_P-1:0]           adr_src_to_exe
);

  logic [PRG_NUM_P-1:0][DATA_WIDTH_P-1:0] r_prf;

  logic                      w_wb_vld  [NUM_PORTS];
  logic [PRG_IDX_BITS_P-1:0] w_wb_idx  [NUM_PORTS];
  logic [DATA_WIDTH_P-1:0]   w_wb_data [NUM_PORTS];

  logic [INST_WIDTH_P-1:0]   w_ins     [NUM_PORTS];
  logic [DATA_WIDTH_P-1:0]   w_src1    [NUM_PORTS];
  logic [DATA_WIDTH_P-1:0]   w_src2    [NUM_PORTS];

  logic [INST_WIDTH_P-1:0]   r_ins_p1  [NUM_PORTS];
  logic [2*DATA_WIDTH_P-1:0] r_src_p1  [NUM_PORTS];

  logic w_fls;
  logic w_unused_fls_idx;

  assign w_fls            = fls_frm_rob[BIT_FLS_VLD];
  // Branch index is irrelevant: every flush here is a full flush.
  assign w_unused_fls_idx = ^fls_frm_rob[BIT_FLS_VLD-1:0];

  assign w_ins[MULT] = mul_ins_frm_is;
  assign w_ins[ADD1] = alu1_ins_frm_is;
  assign w_ins[ADD2] = alu2_ins_frm_is;
  assign w_ins[ADDR] = adr_ins_frm_is;

  // ---- stage p0: writeback decode, operand read with bypass ----
  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_wb
    assign w_wb_vld[k]  = wb_frm_exe[k*WB_WIDTH_P + WB_WIDTH_P - 1];
    assign w_wb_idx[k]  = wb_frm_exe[k*WB_WIDTH_P + DATA_WIDTH_P +: PRG_IDX_BITS_P];
    assign w_wb_data[k] = wb_frm_exe[k*WB_WIDTH_P +: DATA_WIDTH_P];
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    rf_rd_byp #(
      .PRG_NUM_P      (PRG_NUM_P),
      .PRG_IDX_BITS_P (PRG_IDX_BITS_P),
      .DATA_WIDTH_P   (DATA_WIDTH_P),
      .WB_WIDTH_P     (WB_WIDTH_P)
    ) u_src1 (
      .i_src  (w_ins[p][BIT_PSRC1_HI:BIT_PSRC1_LO]),
      .i_prf  (r_prf),
      .i_wb   (wb_frm_exe),
      .o_data (w_src1[p])
    );

    rf_rd_byp #(
      .PRG_NUM_P      (PRG_NUM_P),
      .PRG_IDX_BITS_P (PRG_IDX_BITS_P),
      .DATA_WIDTH_P   (DATA_WIDTH_P),
      .WB_WIDTH_P     (WB_WIDTH_P)
    ) u_src2 (
      .i_src  (w_ins[p][BIT_PSRC2_HI:BIT_PSRC2_LO]),
      .i_prf  (r_prf),
      .i_wb   (wb_frm_exe),
      .o_data (w_src2[p])
    );
  end

  // Register file write; flush does not block writebacks. The ascending
  // loop makes the highest-numbered port win on an index collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prf <= '0;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (w_wb_vld[k]) begin
          r_prf[w_wb_idx[k]] <= w_wb_data[k];
        end
      end
    end
  end

  // ---- stage p1: output registers to execution ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_ins_p1[p] <= '0;
        r_src_p1[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_fls || !w_ins[p][BIT_INST_VLD]) begin
          r_ins_p1[p] <= '0;
          r_src_p1[p] <= '0;
        end else begin
          r_ins_p1[p] <= w_ins[p];
          r_src_p1[p] <= {w_src1[p], w_src2[p]};
        end
      end
    end
  end

  assign mul_ins_to_exe  = r_ins_p1[MULT];
  assign alu1_ins_to_exe = r_ins_p1[ADD1];
  assign alu2_ins_to_exe = r_ins_p1[ADD2];
  assign adr_ins_to_exe  = r_ins_p1[ADDR];
  assign mul_src_to_exe  = r_src_p1[MULT];
  assign alu1_src_to_exe = r_src_p1[ADD1];
  assign alu2_src_to_exe = r_src_p1[ADD2];
  assign adr_src_to_exe  = r_src_p1[ADDR];

endmodule
